// File: rtl/vc_grant_issuer.sv
// Round-robin grant source: one-hot level grant held for a packet of pkt_len flits,
// released with a done/abort pulse, followed by a fixed idle gap before the next arbitration.
module vc_grant_issuer #(
  parameter  int NREQ  = 4,
  parameter  int LEN_W = 4,
  parameter  int GAP   = 1,
  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] pkt_len,
  input  logic                  flit_vld,
  output logic [NREQ-1:0]       gnt,
  output logic [ID_W-1:0]       gnt_id,
  output logic                  busy,
  output logic                  done,
  output logic                  abort
);

  localparam int IDX_W = ID_W + 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [NREQ-1:0]   gnt_reg, gnt_next;
  logic [ID_W-1:0]   gnt_id_reg, gnt_id_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              abort_reg, abort_next;
  logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [LEN_W-1:0]  cnt_reg, cnt_next;
  logic [LEN_W-1:0]  len_m1_reg, len_m1_next;
  logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;

  logic [LEN_W-1:0]  len_field [NREQ];
  logic [LEN_W-1:0]  len_sel;
  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic [IDX_W-1:0]  scan_idx;
  logic              abort_cond;
  logic              done_cond;
  logic              gap_end;
  logic [ID_W-1:0]   rr_after;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_len
    assign len_field[gi] = pkt_len[gi*LEN_W +: LEN_W];
  end

  // Scan requesters starting at rr_ptr, wrapping modulo NREQ; first set bit wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, rr_ptr_reg} + IDX_W'(k);
      if (scan_idx >= IDX_W'(NREQ)) begin
        scan_idx = scan_idx - IDX_W'(NREQ);
      end
      if (!win_found && req[scan_idx[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = scan_idx[ID_W-1:0];
      end
    end
  end

  assign len_sel    = len_field[win_id];
  // Abort wins over completion when both occur on the same edge.
  assign abort_cond = (state_reg == S_GRANT) && !req[gnt_id_reg];
  assign done_cond  = (state_reg == S_GRANT) && req[gnt_id_reg] && flit_vld &&
                      (cnt_reg == len_m1_reg);
  assign gap_end    = (gap_cnt_reg == GAP_W'(GAP - 1));
  assign rr_after   = (gnt_id_reg == ID_W'(NREQ - 1)) ? '0 : gnt_id_reg + 1'b1;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg   <= S_IDLE;
      gnt_reg     <= '0;
      gnt_id_reg  <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      abort_reg   <= 1'b0;
      rr_ptr_reg  <= '0;
      cnt_reg     <= '0;
      len_m1_reg  <= '0;
      gap_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      gnt_id_reg  <= gnt_id_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      abort_reg   <= abort_next;
      rr_ptr_reg  <= rr_ptr_next;
      cnt_reg     <= cnt_next;
      len_m1_reg  <= len_m1_next;
      gap_cnt_reg <= gap_cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (win_found) state_next = S_GRANT;
      S_GRANT: if (abort_cond || done_cond) state_next = S_GAP;
      S_GAP:   if (gap_end) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_next     = gnt_reg;
    gnt_id_next  = gnt_id_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    abort_next   = 1'b0;
    rr_ptr_next  = rr_ptr_reg;
    cnt_next     = cnt_reg;
    len_m1_next  = len_m1_reg;
    gap_cnt_next = gap_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (win_found) begin
          gnt_next         = '0;
          gnt_next[win_id] = 1'b1;
          gnt_id_next      = win_id;
          busy_next        = 1'b1;
          cnt_next         = '0;
          // A zero-length packet is treated as one flit.
          len_m1_next      = (len_sel == '0) ? '0 : len_sel - 1'b1;
        end
      end
      S_GRANT: begin
        if (abort_cond || done_cond) begin
          gnt_next     = '0;
          busy_next    = 1'b0;
          abort_next   = abort_cond;
          done_next    = !abort_cond;
          rr_ptr_next  = rr_after;
          gap_cnt_next = '0;
        end else if (flit_vld) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_GAP: begin
        if (!gap_end) begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end
      default: begin
        gnt_next  = '0;
        busy_next = 1'b0;
      end
    endcase
  end

  assign gnt    = gnt_reg;
  assign gnt_id = gnt_id_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;
  assign abort  = abort_reg;

endmodule
